word_serializer: RTL and testbench

Parallel-to-serial unloader for four-word register groups. Captures four N-bit words in one handshake and emits them one word per beat on a valid/ready stream, in index order 0..3, with a last-word flag. It is the read-out end of the datapath's four-wide register banks, feeding narrow downstream consumers.

---
 rtl/word_serializer_pkg.sv | 13 +
 rtl/register.sv | 20 ++
 rtl/word_serializer.sv | 79 +++++++
 tb/tb_word_serializer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// rtl/word_serializer_pkg.sv - shared types and constants for the four-word serializer
package word_serializer_pkg;

  localparam int IDX_W = 2;
  localparam int WORDS = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/register.sv
// rtl/register.sv - N-bit enabled register with asynchronous active-low reset
module register #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - captures four N-bit words in one handshake and streams them in index order
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     In0,
  input  logic [N-1:0]     In1,
  input  logic [N-1:0]     In2,
  input  logic [N-1:0]     In3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             load;
  logic             beat;
  logic [N-1:0]     in_word [WORDS];
  logic [N-1:0]     hold    [WORDS];

  assign in_word[0] = In0;
  assign in_word[1] = In1;
  assign in_word[2] = In2;
  assign in_word[3] = In3;

  for (genvar i = 0; i < WORDS; i++) begin : g_hold
    register #(.N(N)) u_hold (
      .clk (clk),
      .rst (rst),
      .en  (load),
      .d   (in_word[i]),
      .q   (hold[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Accepting a new group on the final beat keeps groups back-to-back with no bubble.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    in_ready = (state == IDLE) || ((idx == LAST_IDX) && out_ready);
    load     = in_valid && in_ready;
    beat     = (state == SEND) && out_ready;
    if (load) begin
      state_n = SEND;
      idx_n   = '0;
    end else if (beat) begin
      if (idx == LAST_IDX) begin
        state_n = IDLE;
        idx_n   = '0;
      end else begin
        idx_n = idx + 1'b1;
      end
    end
  end

  assign out_valid = (state == SEND);
  assign out_data  = hold[idx];
  assign out_idx   = idx;
  assign out_last  = out_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - table-driven check of word_serializer plus reset and restart sequence
module tb_word_serializer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in0, in1, in2, in3;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [1:0] out_idx;
  logic       out_last;

  int vec_count;
  int err_count;

  typedef struct {
    logic       iv;
    logic [4:0] a, b, c, d;
    logic       ordy;
    logic       ov;
    logic [4:0] od;
    logic [1:0] oi;
    logic       ol;
    logic       ir;
  } vec_t;

  vec_t vecs[$];

  word_serializer #(.N(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In0       (in0),
    .In1       (in1),
    .In2       (in2),
    .In3       (in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, int a, int b, int c, int d, logic ordy,
                              logic ov, int od, int oi, logic ol, logic ir);
    vec_t v;
    v.iv = iv; v.a = 5'(a); v.b = 5'(b); v.c = 5'(c); v.d = 5'(d); v.ordy = ordy;
    v.ov = ov; v.od = 5'(od); v.oi = 2'(oi); v.ol = ol; v.ir = ir;
    return v;
  endfunction

  task automatic check(string name, int got, int exp);
    vec_count++;
    if (got != exp) begin
      err_count++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;

    // single group 1..4
    vecs.push_back(mk(1, 1, 2, 3, 4, 1,   0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 3, 4, 1,   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 3, 4, 1,   1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 2, 3, 4, 1,   1, 3, 2, 0, 0));
    vecs.push_back(mk(0, 1, 2, 3, 4, 1,   1, 4, 3, 1, 1));
    // back-to-back groups A then B
    vecs.push_back(mk(1, 5, 6, 7, 8, 1,   0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 5, 6, 7, 8, 1,   1, 5, 0, 0, 0));
    vecs.push_back(mk(1, 5, 6, 7, 8, 1,   1, 6, 1, 0, 0));
    vecs.push_back(mk(1, 5, 6, 7, 8, 1,   1, 7, 2, 0, 0));
    vecs.push_back(mk(1, 9, 10, 11, 12, 1, 1, 8, 3, 1, 1));
    vecs.push_back(mk(1, 9, 10, 11, 12, 1, 1, 9, 0, 0, 0));
    vecs.push_back(mk(1, 9, 10, 11, 12, 1, 1, 10, 1, 0, 0));
    vecs.push_back(mk(1, 9, 10, 11, 12, 1, 1, 11, 2, 0, 0));
    vecs.push_back(mk(0, 9, 10, 11, 12, 1, 1, 12, 3, 1, 1));
    // backpressure at idx 1 with In* disturbed during the stall
    vecs.push_back(mk(1, 17, 18, 19, 20, 1, 0, 9, 0, 0, 1));
    vecs.push_back(mk(0, 17, 18, 19, 20, 1, 1, 17, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0,    1, 18, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0,    1, 18, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0,    1, 18, 1, 0, 0));
    vecs.push_back(mk(0, 17, 18, 19, 20, 1, 1, 18, 1, 0, 0));
    vecs.push_back(mk(0, 17, 18, 19, 20, 1, 1, 19, 2, 0, 0));
    // not ready at last word with a pending group
    vecs.push_back(mk(1, 3, 3, 3, 3, 0,    1, 20, 3, 1, 0));
    vecs.push_back(mk(1, 3, 3, 3, 3, 0,    1, 20, 3, 1, 0));
    vecs.push_back(mk(0, 3, 3, 3, 3, 1,    1, 20, 3, 1, 1));
    // width corners
    vecs.push_back(mk(1, 31, 0, 31, 0, 1,  0, 17, 0, 0, 1));
    vecs.push_back(mk(0, 31, 0, 31, 0, 1,  1, 31, 0, 0, 0));
    vecs.push_back(mk(0, 31, 0, 31, 0, 1,  1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 31, 0, 31, 0, 1,  1, 31, 2, 0, 0));
    vecs.push_back(mk(0, 31, 0, 31, 0, 1,  1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 31, 0, 31, 0, 1,  0, 31, 0, 0, 1));

    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = vecs[i].iv;
      in0 = vecs[i].a; in1 = vecs[i].b; in2 = vecs[i].c; in3 = vecs[i].d;
      out_ready = vecs[i].ordy;
      #1;
      vec_count++;
      if ({out_valid, out_data, out_idx, out_last, in_ready} !==
          {vecs[i].ov, vecs[i].od, vecs[i].oi, vecs[i].ol, vecs[i].ir}) begin
        err_count++;
        $display("FAIL vec%0d: got valid=%0b data=%0d idx=%0d last=%0b in_ready=%0b expected valid=%0b data=%0d idx=%0d last=%0b in_ready=%0b",
                 i, out_valid, out_data, out_idx, out_last, in_ready,
                 vecs[i].ov, vecs[i].od, vecs[i].oi, vecs[i].ol, vecs[i].ir);
      end
    end

    // mid-group reset at idx 2, then restart with 1..4
    @(negedge clk);
    in_valid = 1'b1; in0 = 5'd1; in1 = 5'd2; in2 = 5'd3; in3 = 5'd4; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_idx", out_idx, 2);
    check("pre_reset_data", out_data, 3);
    #2;
    rst = 1'b0;
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_idx", out_idx, 0);
    check("reset_last", out_last, 0);
    @(negedge clk);
    #1;
    check("reset_hold_valid", out_valid, 0);
    rst = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    check("release_valid", out_valid, 0);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check($sformatf("restart_valid%0d", k), out_valid, 1);
      check($sformatf("restart_data%0d", k), out_data, k + 1);
      check($sformatf("restart_idx%0d", k), out_idx, k);
      check($sformatf("restart_last%0d", k), out_last, (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    #1;
    check("restart_end_valid", out_valid, 0);
    check("restart_end_in_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
